// File: rtl/irq_pkg.sv
// Shared constants, FSM state type and priority encoder
// for the interrupt pending latch.
package irq_pkg;

    localparam int IRQ_N    = 4;
    localparam int IRQ_ID_W = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_t;

    // Highest set index wins
    function automatic logic [1:0] prio_enc4(logic [3:0] v);
        logic [1:0] r;
        if (v[3])      r = 2'd3;
        else if (v[2]) r = 2'd2;
        else if (v[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request, handshake and status bundle between
// the interrupt source side and the pending latch.
interface irq_pending_latch_if;
    import irq_pkg::*;

    logic [IRQ_N-1:0]    irq_in;
    logic [IRQ_N-1:0]    irq_mask;
    logic                irq_ack;
    logic                irq_valid;
    logic [IRQ_ID_W-1:0] irq_id;
    logic [IRQ_N-1:0]    pending;
    logic [IRQ_N-1:0]    missed;

    modport master (
        output irq_in, irq_mask, irq_ack,
        input  irq_valid, irq_id, pending, missed
    );

    modport slave (
        input  irq_in, irq_mask, irq_ack,
        output irq_valid, irq_id, pending, missed
    );

endinterface

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer plus delay flop; pulses
// one cycle on each synchronized rising edge.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending/missed registers, priority select
// and valid/ack presentation FSM.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter int N    = IRQ_N,
    parameter int ID_W = IRQ_ID_W
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_pending_latch_if.slave   bus
);

    logic [N-1:0]    rise;
    logic [N-1:0]    clr;
    logic [N-1:0]    eligible;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    missed_q, missed_d;
    logic [ID_W-1:0] id_q, id_d;
    irq_state_t      state_q, state_d;

    for (genvar i = 0; i < N; i++) begin : g_sync
        irq_edge_sync u_sync (
            .clk        (clk),
            .rst        (rst),
            .async_in   (bus.irq_in[i]),
            .rise_pulse (rise[i])
        );
    end

    assign eligible = pending_q & bus.irq_mask;

    // A new edge on the bit being cleared wins over the clear
    always_comb begin
        clr = '0;
        if (state_q == PRESENT && bus.irq_ack)
            clr[id_q] = 1'b1;
        pending_d = (pending_q & ~clr) | rise;
        missed_d  = (missed_q & ~clr) | (rise & pending_q & ~clr);
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = PRESENT;
                    id_d    = prio_enc4(eligible);
                end
            end
            PRESENT: begin
                if (bus.irq_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            missed_q  <= '0;
            id_q      <= '0;
            state_q   <= IDLE;
        end else begin
            pending_q <= pending_d;
            missed_q  <= missed_d;
            id_q      <= id_d;
            state_q   <= state_d;
        end
    end

    assign bus.irq_valid = (state_q == PRESENT);
    assign bus.irq_id    = id_q;
    assign bus.pending   = pending_q;
    assign bus.missed    = missed_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Table-driven bench with a presentation-order
// scoreboard for irq_pending_latch.
module tb_irq_pending_latch;
    import irq_pkg::*;

    typedef struct {
        logic [3:0] irq;
        logic [3:0] mask;
        logic       ack;
        logic       v;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] miss;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    irq_pending_latch_if bus ();

    irq_pending_latch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];
    logic [1:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(logic [3:0] i, logic [3:0] m, logic a,
                                logic v, logic [1:0] id,
                                logic [3:0] p, logic [3:0] ms);
        vec_t r;
        r.irq = i; r.mask = m; r.ack = a;
        r.v = v; r.id = id; r.pend = p; r.miss = ms;
        vecs.push_back(r);
    endfunction

    // Presentation monitor: order from the scoreboard, id held while valid
    logic       pv = 1'b0;
    logic [1:0] pid = 2'd0;
    always @(posedge clk) begin
        logic [1:0] e;
        #1;
        if (bus.irq_valid && !pv) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_order: unexpected id %0d presented, none expected",
                         bus.irq_id);
            end else begin
                e = exp_q.pop_front();
                if (bus.irq_id !== e) begin
                    fails++;
                    $display("FAIL sb_order: got id %0d expected %0d", bus.irq_id, e);
                end
            end
        end else if (bus.irq_valid && pv) begin
            tests++;
            if (bus.irq_id !== pid) begin
                fails++;
                $display("FAIL id_stable: got %0d expected %0d", bus.irq_id, pid);
            end
        end
        pv  = bus.irq_valid;
        pid = bus.irq_id;
    end

    initial begin
        bus.irq_in   = 4'h0;
        bus.irq_mask = 4'hF;
        bus.irq_ack  = 1'b0;

        // single request on line 1
        add(4'b0010, 4'hF, 0, 0, 0, 4'b0000, 0);
        add(4'b0010, 4'hF, 0, 0, 0, 4'b0000, 0);
        add(4'b0010, 4'hF, 0, 0, 0, 4'b0010, 0);
        add(4'b0010, 4'hF, 0, 1, 1, 4'b0010, 0);
        add(4'b0000, 4'hF, 1, 0, 1, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 1, 4'b0000, 0);
        // lines 0,2,3 together: order 3,2,0
        add(4'b1101, 4'hF, 0, 0, 1, 4'b0000, 0);
        add(4'b1101, 4'hF, 0, 0, 1, 4'b0000, 0);
        add(4'b1101, 4'hF, 0, 0, 1, 4'b1101, 0);
        add(4'b1101, 4'hF, 0, 1, 3, 4'b1101, 0);
        add(4'b0000, 4'hF, 1, 0, 3, 4'b0101, 0);
        add(4'b0000, 4'hF, 0, 1, 2, 4'b0101, 0);
        add(4'b0000, 4'hF, 1, 0, 2, 4'b0001, 0);
        add(4'b0000, 4'hF, 0, 1, 0, 4'b0001, 0);
        add(4'b0000, 4'hF, 1, 0, 0, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 0, 4'b0000, 0);
        // line 2 masked, then unmasked, then masked while presented
        add(4'b0100, 4'hB, 0, 0, 0, 4'b0000, 0);
        add(4'b0100, 4'hB, 0, 0, 0, 4'b0000, 0);
        add(4'b0100, 4'hB, 0, 0, 0, 4'b0100, 0);
        add(4'b0000, 4'hB, 0, 0, 0, 4'b0100, 0);
        add(4'b0000, 4'hF, 0, 1, 2, 4'b0100, 0);
        add(4'b0000, 4'hB, 1, 0, 2, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 2, 4'b0000, 0);
        // hold id 1 while line 3 arrives
        add(4'b0010, 4'hF, 0, 0, 2, 4'b0000, 0);
        add(4'b0010, 4'hF, 0, 0, 2, 4'b0000, 0);
        add(4'b0010, 4'hF, 0, 0, 2, 4'b0010, 0);
        add(4'b0010, 4'hF, 0, 1, 1, 4'b0010, 0);
        add(4'b1010, 4'hF, 0, 1, 1, 4'b0010, 0);
        add(4'b1010, 4'hF, 0, 1, 1, 4'b0010, 0);
        add(4'b1010, 4'hF, 0, 1, 1, 4'b1010, 0);
        add(4'b0000, 4'hF, 1, 0, 1, 4'b1000, 0);
        add(4'b0000, 4'hF, 0, 1, 3, 4'b1000, 0);
        add(4'b0000, 4'hF, 1, 0, 3, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 3, 4'b0000, 0);
        // second pulse on pending line 0 -> missed
        add(4'b0001, 4'hF, 0, 0, 3, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 3, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 3, 4'b0001, 0);
        add(4'b0001, 4'hF, 0, 1, 0, 4'b0001, 0);
        add(4'b0000, 4'hF, 0, 1, 0, 4'b0001, 0);
        add(4'b0000, 4'hF, 0, 1, 0, 4'b0001, 4'b0001);
        add(4'b0000, 4'hF, 1, 0, 0, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 0, 4'b0000, 0);
        // edge coincident with ack clear: set wins, no miss
        add(4'b0001, 4'hF, 0, 0, 0, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 0, 4'b0000, 0);
        add(4'b0001, 4'hF, 0, 0, 0, 4'b0001, 0);
        add(4'b0000, 4'hF, 0, 1, 0, 4'b0001, 0);
        add(4'b0000, 4'hF, 1, 0, 0, 4'b0001, 0);
        add(4'b0000, 4'hF, 0, 1, 0, 4'b0001, 0);
        add(4'b0000, 4'hF, 1, 0, 0, 4'b0000, 0);
        add(4'b0000, 4'hF, 0, 0, 0, 4'b0000, 0);

        // reset state and stray acks
        repeat (3) step();
        chk("rst_valid", 32'(bus.irq_valid), 0);
        chk("rst_id", 32'(bus.irq_id), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_missed", 32'(bus.missed), 0);
        rst = 1'b0;
        bus.irq_ack = 1'b1; step();
        bus.irq_ack = 1'b0; step();
        bus.irq_ack = 1'b1; step();
        bus.irq_ack = 1'b0; step();
        chk("stray_ack_valid", 32'(bus.irq_valid), 0);
        chk("stray_ack_pending", 32'(bus.pending), 0);
        chk("stray_ack_missed", 32'(bus.missed), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.irq_in   = vecs[i].irq;
            bus.irq_mask = vecs[i].mask;
            bus.irq_ack  = vecs[i].ack;
            if (vecs[i].v && !(i > 0 && vecs[i-1].v))
                exp_q.push_back(vecs[i].id);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.irq_valid), 32'(vecs[i].v));
            chk($sformatf("vec%0d_id", i), 32'(bus.irq_id), 32'(vecs[i].id));
            chk($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(vecs[i].pend));
            chk($sformatf("vec%0d_missed", i), 32'(bus.missed), 32'(vecs[i].miss));
        end
        bus.irq_ack = 1'b0;

        // reset while presenting line 3, line held high through release
        bus.irq_in = 4'b1000;
        exp_q.push_back(2'd3);
        repeat (4) step();
        chk("midrst_pre_valid", 32'(bus.irq_valid), 1);
        chk("midrst_pre_id", 32'(bus.irq_id), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.irq_valid), 0);
        chk("midrst_pending", 32'(bus.pending), 0);
        chk("midrst_missed", 32'(bus.missed), 0);
        step();
        step();
        rst = 1'b0;
        exp_q.push_back(2'd3);
        repeat (3) step();
        chk("lvl_rel_early", 32'(bus.irq_valid), 0);
        chk("lvl_rel_pend", 32'(bus.pending), 4'b1000);
        step();
        chk("lvl_rel_valid", 32'(bus.irq_valid), 1);
        chk("lvl_rel_id", 32'(bus.irq_id), 3);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("lvl_ack_valid", 32'(bus.irq_valid), 0);
        chk("lvl_ack_pending", 32'(bus.pending), 0);
        repeat (6) step();
        chk("lvl_one_edge_valid", 32'(bus.irq_valid), 0);
        chk("lvl_one_edge_pend", 32'(bus.pending), 0);
        bus.irq_in = 4'b0000;
        repeat (2) step();

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
